// File: rtl/interpolation_unit_window_fetch_pkg.sv
// Shared types for the interpolation window fetcher: FSM states and the
// 5-bit patch index used for win_dim and the row/column counters.
package interpolation_unit_window_fetch_pkg;
  localparam int WIN_W = 5;
  typedef logic [WIN_W-1:0] win_idx_t;
  typedef enum logic [1:0] {IDLE, BASE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/interpolation_unit_window_fetch_if.sv
// Bundle of feature-request, frame-memory and pixel-stream signals.
// master = the environment (feature source, memory, consumer); slave = the fetch unit.
interface interpolation_unit_window_fetch_if #(
  parameter int pix_width   = 9,
  parameter int dec_width   = 15,
  parameter int coord_width = 10,
  parameter int addr_width  = 20
);
  import interpolation_unit_window_fetch_pkg::*;

  win_idx_t               win_dim;
  logic [coord_width-1:0] img_width;
  logic                   feat_val;
  logic                   feat_rdy;
  logic [coord_width-1:0] feat_x;
  logic [coord_width-1:0] feat_y;
  logic [dec_width-1:0]   feat_a;
  logic [dec_width-1:0]   feat_b;
  logic                   mem_req_val;
  logic [addr_width-1:0]  mem_req_addr;
  logic [pix_width-1:0]   mem_resp_data;
  logic                   pix_val;
  logic                   out_rdy;
  logic [pix_width-1:0]   pix_out;
  win_idx_t               col_counter;
  win_idx_t               row_counter;
  logic                   feature_val;
  logic [dec_width-1:0]   frac_a;
  logic [dec_width-1:0]   frac_b;

  modport master (
    output win_dim, img_width, feat_val, feat_x, feat_y, feat_a, feat_b,
           mem_resp_data, out_rdy,
    input  feat_rdy, mem_req_val, mem_req_addr, pix_val, pix_out,
           col_counter, row_counter, feature_val, frac_a, frac_b
  );

  modport slave (
    input  win_dim, img_width, feat_val, feat_x, feat_y, feat_a, feat_b,
           mem_resp_data, out_rdy,
    output feat_rdy, mem_req_val, mem_req_addr, pix_val, pix_out,
           col_counter, row_counter, feature_val, frac_a, frac_b
  );
endinterface

// File: rtl/interpolation_unit_resp_buffer.sv
// Small circular FIFO holding returned pixels; accepts a push while full
// when the head is popped in the same cycle.
module interpolation_unit_resp_buffer #(
  parameter  int width = 9,
  parameter  int depth = 3,
  localparam int CW    = $clog2(depth + 1),
  localparam int PTR   = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [width-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [width-1:0] out_data,
  output logic [CW-1:0]    occ
);
  logic [width-1:0] mem [depth];
  logic [PTR-1:0]   wp, rp;
  logic [CW-1:0]    cnt;
  logic             push, pop;

  function automatic logic [PTR-1:0] inc(input logic [PTR-1:0] p);
    return (p == PTR'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_val  = (cnt != '0);
  assign in_rdy   = (cnt != CW'(depth)) || out_rdy;
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;
  assign out_data = mem[rp];
  assign occ      = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp      <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/interpolation_unit_window_fetch.sv
// Walks a (win_dim+1)^2 pixel patch row-major, issues fixed-latency frame
// memory reads under a credit limit and streams pixels with their indices.
module interpolation_unit_window_fetch
  import interpolation_unit_window_fetch_pkg::*;
#(
  parameter int pix_width   = 9,
  parameter int dec_width   = 15,
  parameter int coord_width = 10,
  parameter int addr_width  = 20,
  parameter int mem_lat     = 2
) (
  input logic clk,
  input logic reset_n,
  interpolation_unit_window_fetch_if.slave io
);
  localparam int D  = mem_lat + 1;
  localparam int CW = $clog2(D + 1);
  localparam int PW = 2 * coord_width + 1;

  state_t                 state, state_nx;
  logic                   up;
  win_idx_t               wd_q, icol, irow, ocol, orow;
  logic [coord_width-1:0] x_q, y_q, iw_q;
  logic [dec_width-1:0]   a_q, b_q;
  logic [addr_width-1:0]  row_base;
  logic [PW-1:0]          base_full;
  logic [mem_lat:1]       vld_pipe;
  logic [CW-1:0]          inflight, occ;
  logic [CW:0]            load;
  logic                   accept, credit, issue, last_issue, pop;
  logic                   buf_val, buf_rdy;
  logic [pix_width-1:0]   head;

  assign io.feat_rdy = up && (state == IDLE);
  assign accept      = io.feat_rdy && io.feat_val;
  assign pop         = buf_val && io.out_rdy;
  // A head popped this cycle frees its slot in time for a new request,
  // which is what lets the stream run at one pixel per cycle.
  assign load        = {1'b0, occ} + {1'b0, inflight} - {{CW{1'b0}}, pop};
  assign credit      = load < (CW + 1)'(D);
  assign issue       = (state == ISSUE) && credit;
  assign last_issue  = (icol == wd_q) && (irow == wd_q);
  assign base_full   = PW'(y_q) * PW'(iw_q) + PW'(x_q);

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= mem_lat; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      up    <= 1'b0;
    end else begin
      state <= state_nx;
      up    <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = BASE;
      BASE:  state_nx = ISSUE;
      ISSUE: if (issue && last_issue) state_nx = DRAIN;
      DRAIN: if (inflight == '0 && (occ == '0 || (occ == CW'(1) && pop)))
               state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      iw_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      row_base <= '0;
      icol     <= '0;
      irow     <= '0;
      ocol     <= '0;
      orow     <= '0;
      vld_pipe <= '0;
    end else begin
      if (accept) begin
        wd_q <= io.win_dim;
        x_q  <= io.feat_x;
        y_q  <= io.feat_y;
        iw_q <= io.img_width;
        a_q  <= io.feat_a;
        b_q  <= io.feat_b;
      end
      if (state == BASE) begin
        row_base <= addr_width'(base_full);
        icol     <= '0;
        irow     <= '0;
      end else if (issue) begin
        if (icol == wd_q) begin
          icol     <= '0;
          irow     <= irow + 5'd1;
          row_base <= row_base + addr_width'(iw_q);
        end else begin
          icol <= icol + 5'd1;
        end
      end
      vld_pipe[1] <= issue;
      for (int i = 2; i <= mem_lat; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (pop) begin
        if (ocol == wd_q) begin
          ocol <= '0;
          orow <= (orow == wd_q) ? '0 : orow + 5'd1;
        end else begin
          ocol <= ocol + 5'd1;
        end
      end
    end
  end

  interpolation_unit_resp_buffer #(.width(pix_width), .depth(D)) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_val   (vld_pipe[mem_lat] && buf_rdy),
    .in_rdy   (buf_rdy),
    .in_data  (io.mem_resp_data),
    .out_val  (buf_val),
    .out_rdy  (io.out_rdy),
    .out_data (head),
    .occ      (occ)
  );

  assign io.mem_req_val  = issue;
  assign io.mem_req_addr = issue ? row_base + addr_width'(icol) : '0;
  assign io.pix_val      = buf_val;
  assign io.pix_out      = buf_val ? head : '0;
  assign io.col_counter  = ocol;
  assign io.row_counter  = orow;
  assign io.feature_val  = buf_val && (ocol == '0) && (orow == '0);
  assign io.frac_a       = a_q;
  assign io.frac_b       = b_q;
endmodule

// File: tb/tb_interpolation_unit_window_fetch.sv
// Randomised bench for the window fetcher: a cycle-level model of the issue
// credit rule and patch ordering is compared with the DUT on every cycle.
module tb_interpolation_unit_window_fetch;
  import interpolation_unit_window_fetch_pkg::*;

  localparam int PW = 9, DW = 15, CWD = 10, AW = 20, LAT = 2, D = LAT + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  interpolation_unit_window_fetch_if #(.pix_width(PW), .dec_width(DW),
    .coord_width(CWD), .addr_width(AW)) bus ();

  interpolation_unit_window_fetch #(.pix_width(PW), .dec_width(DW),
    .coord_width(CWD), .addr_width(AW), .mem_lat(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .io(bus.slave));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mem_word(input logic [AW-1:0] a);
    return a[8:0] ^ a[17:9] ^ {7'd0, a[19:18]} ^ 9'h0A5;
  endfunction

  // frame memory: data for a strobe appears exactly LAT cycles later, junk otherwise
  logic [AW-1:0] ma [1:LAT];
  logic          mv [1:LAT];
  logic [PW-1:0] junk;
  always @(posedge clk) begin
    mv[1] <= bus.mem_req_val;
    ma[1] <= bus.mem_req_addr;
    for (int i = 2; i <= LAT; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
    junk <= PW'($urandom);
  end
  assign bus.mem_resp_data = mv[LAT] ? mem_word(ma[LAT]) : junk;

  // behavioural model state
  int            cyc = 0;
  bit            active = 0, exp_rdy = 0, post_rst = 0, all_rdy = 0;
  bit            rdy_now, epv, popn, ereq;
  int            acc_cyc, n_pix, iss, popc, m_wd, last_dur;
  int            iss_cyc [0:255];
  logic [AW-1:0] exp_addr [0:255];
  logic [DW-1:0] m_a, m_b;
  longint        av;
  logic [AW-1:0] req_log [$];
  int            req_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("reset_datapath", {bus.mem_req_addr, bus.pix_out, bus.col_counter, bus.row_counter}, 0);
      chk("reset_control", {bus.feat_rdy, bus.mem_req_val, bus.pix_val, bus.feature_val,
                            bus.frac_a, bus.frac_b}, 0);
      active = 0; exp_rdy = 0; post_rst = 1;
    end else begin
      rdy_now = exp_rdy;
      epv  = active && popc < iss && cyc >= iss_cyc[popc] + LAT + 1;
      popn = epv && bus.out_rdy;
      ereq = active && cyc >= acc_cyc + 2 && iss < n_pix && (iss - popc - int'(popn)) < D;
      chk("mem_req_val", bus.mem_req_val, ereq);
      if (ereq) begin
        chk("mem_req_addr", bus.mem_req_addr, exp_addr[iss]);
        req_log.push_back(bus.mem_req_addr);
        req_cyc.push_back(cyc);
        iss_cyc[iss] = cyc;
        iss++;
      end
      chk("pix_val", bus.pix_val, epv);
      if (epv) begin
        chk("pix_out", bus.pix_out, mem_word(exp_addr[popc]));
        chk("col_counter", bus.col_counter, popc % (m_wd + 1));
        chk("row_counter", bus.row_counter, popc / (m_wd + 1));
        chk("feature_val", bus.feature_val, popc == 0);
        chk("frac_a", bus.frac_a, m_a);
        chk("frac_b", bus.frac_b, m_b);
        if (!bus.out_rdy) all_rdy = 0;
      end else begin
        chk("feature_val_idle", bus.feature_val, 0);
      end
      chk("feat_rdy", bus.feat_rdy, rdy_now);
      if (popn) begin
        popc++;
        if (popc == n_pix) begin
          active = 0;
          exp_rdy = 1;
          last_dur = cyc - acc_cyc;
          if (all_rdy) chk("window_cycles", last_dur, LAT + 2 + n_pix);
        end
      end
      if (post_rst) begin
        exp_rdy = 1;
        post_rst = 0;
      end
      if (bus.feat_val && rdy_now) begin
        m_wd  = int'(bus.win_dim);
        m_a   = bus.feat_a;
        m_b   = bus.feat_b;
        n_pix = (m_wd + 1) * (m_wd + 1);
        for (int k = 0; k < n_pix; k++) begin
          av = (longint'(bus.feat_y) + k / (m_wd + 1)) * longint'(bus.img_width)
               + longint'(bus.feat_x) + k % (m_wd + 1);
          exp_addr[k] = AW'(av);
        end
        active = 1; acc_cyc = cyc; iss = 0; popc = 0; all_rdy = 1; exp_rdy = 0;
      end
    end
  end

  // downstream ready: 0 = held high, 1 = random, 2 = held low
  int rdy_mode = 0;
  initial begin
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_rdy = 1'b1;
        1:       bus.out_rdy = 1'($urandom_range(0, 1));
        default: bus.out_rdy = 1'b0;
      endcase
    end
  end

  task automatic scramble();
    bus.win_dim   = 5'($urandom);
    bus.img_width = CWD'($urandom);
    bus.feat_x    = CWD'($urandom);
    bus.feat_y    = CWD'($urandom);
    bus.feat_a    = DW'($urandom);
    bus.feat_b    = DW'($urandom);
  endtask

  task automatic send(input int wd, input int iw, input int x, input int y,
                      input int a, input int b);
    bus.win_dim = 5'(wd); bus.img_width = CWD'(iw);
    bus.feat_x = CWD'(x); bus.feat_y = CWD'(y);
    bus.feat_a = DW'(a); bus.feat_b = DW'(b);
    bus.feat_val = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bus.feat_rdy) begin
        @(posedge clk); #1;
        bus.feat_val = 1'b0;
        scramble();
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    bus.feat_val = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (bus.feat_rdy) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bus.feat_val = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 2x2 patch at (2,3), stride 8
    req_log.delete(); req_cyc.delete();
    send(1, 8, 2, 3, 100, 200);
    wait_done();
    chk("t1_nreq", req_log.size(), 4);
    chk("t1_addr0", req_log[0], 26);
    chk("t1_addr1", req_log[1], 27);
    chk("t1_addr2", req_log[2], 34);
    chk("t1_addr3", req_log[3], 35);
    chk("t1_back_to_back", req_cyc[3] - req_cyc[0], 3);
    chk("t1_duration", last_dur, 8);

    // full 16x16 patch at full rate
    req_log.delete();
    send(15, 40, 5, 7, 11, 22);
    wait_done();
    chk("t2_nreq", req_log.size(), 256);
    chk("t2_duration", last_dur, 260);

    // same patch under random backpressure, including a long stall
    rdy_mode = 1;
    send(15, 40, 5, 7, 33, 44);
    repeat (40) @(posedge clk);
    #1 rdy_mode = 2;
    repeat (10) @(posedge clk);
    #1 rdy_mode = 1;
    wait_done();
    rdy_mode = 0;

    // single-pixel window at the origin
    req_log.delete();
    send(0, 17, 0, 0, 5, 6);
    wait_done();
    chk("t4_nreq", req_log.size(), 1);
    chk("t4_addr", req_log[0], 0);
    chk("t4_duration", last_dur, 5);

    // second feature presented while the first is still in flight
    send(3, 20, 4, 4, 1000, 2000);
    send(2, 30, 9, 1, 3000, 4000);
    wait_done();

    // reset in the middle of issuing
    send(15, 100, 10, 10, 7, 8);
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_datapath", {bus.mem_req_addr, bus.pix_out, bus.col_counter, bus.row_counter}, 0);
    chk("async_reset_control", {bus.feat_rdy, bus.mem_req_val, bus.pix_val, bus.feature_val,
                                bus.frac_a, bus.frac_b}, 0);
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    send(2, 50, 3, 3, 9, 10);
    wait_done();

    // address wrap at the 2^20 boundary
    req_log.delete();
    send(1, 1023, 1023, 1023, 12, 13);
    wait_done();
    chk("t7_addr0", req_log[0], 1047552);
    chk("t7_addr1", req_log[1], 1047553);
    chk("t7_addr2", req_log[2], 1048575);
    chk("t7_addr3", req_log[3], 0);

    // random features and backpressure
    for (int n = 0; n < 25; n++) begin
      rdy_mode = $urandom_range(0, 1);
      send($urandom_range(0, 7), $urandom_range(1, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom, $urandom);
    end
    wait_done();
    rdy_mode = 0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
